// File: rtl/phys_reg_tracker_if.sv
// ---------------------------------------------------------------------------
// phys_reg_tracker_if
//   Allocation bus between dispatch and the physical-register tracker.
//   Dispatch asks for up to ALLOC_W registers per cycle. The tracker answers
//   in the same cycle with an all-or-nothing grant and the candidate indices.
//
//   alloc_req  : number of pregs requested this cycle (0..ALLOC_W)
//   alloc_gnt  : request granted (combinational)
//   alloc_idx  : lowest-index free pregs, slot 0 = lowest (combinational)
//   free_count : registered popcount of the free list
//
//   master : dispatch side
//   slave  : tracker side
// ---------------------------------------------------------------------------
interface phys_reg_tracker_if #(
  parameter int NUM_PREGS = 64,
  parameter int ALLOC_W   = 3
);
  localparam int PW = $clog2(NUM_PREGS);
  localparam int AW = $clog2(ALLOC_W + 1);
  localparam int FW = $clog2(NUM_PREGS + 1);

  logic [AW-1:0]              alloc_req;
  logic                       alloc_gnt;
  logic [ALLOC_W-1:0][PW-1:0] alloc_idx;
  logic [FW-1:0]              free_count;

  modport master (
    output alloc_req,
    input  alloc_gnt,
    input  alloc_idx,
    input  free_count
  );

  modport slave (
    input  alloc_req,
    output alloc_gnt,
    output alloc_idx,
    output free_count
  );
endinterface

// File: rtl/phys_reg_tracker.sv
// ---------------------------------------------------------------------------
// phys_reg_tracker
//   Physical-register free list and ready list for the R10K rename stage,
//   with NUM_CKPT branch checkpoints of the free list.
//
//   The free list hands out the lowest-index free pregs to dispatch with an
//   all-or-nothing grant. Retired T_old registers return to the free list
//   and are also merged into every valid checkpoint. A restore on a
//   mispredict therefore yields an exact free list: the speculative
//   allocations are undone and no retirement is lost. Completions on the CDB
//   set ready bits. Allocation clears them.
//
// Ports
//   clock              : rising-edge clock
//   reset              : asynchronous active-low reset
//   alloc_bus          : allocation request/grant bus (slave side)
//   cmp_valid/cmp_idx  : CDB completions (T_new)
//   ret_valid/ret_idx  : retirements (T_old returned to the free list)
//   ckpt_save/_id      : snapshot the post-cycle free list into a slot
//   ckpt_restore/_id   : mispredict; reload the free list from a slot
//   ckpt_release/_id   : branch resolved correctly; invalidate the slot
//   ready_list         : registered ready bits
//   next_ready_list    : next-state ready bits (issue wakeup bypass)
//   free_list          : registered free bits
// ---------------------------------------------------------------------------
module phys_reg_tracker #(
  parameter  int NUM_PREGS = 64,
  parameter  int NUM_AREGS = 32,
  parameter  int ALLOC_W   = 3,
  parameter  int CMP_W     = 3,
  parameter  int RET_W     = 3,
  parameter  int NUM_CKPT  = 8,
  localparam int PW        = $clog2(NUM_PREGS),
  localparam int CW        = $clog2(NUM_CKPT),
  localparam int AW        = $clog2(ALLOC_W + 1),
  localparam int FW        = $clog2(NUM_PREGS + 1)
) (
  input  logic                      clock,
  input  logic                      reset,

  phys_reg_tracker_if.slave         alloc_bus,

  input  logic [CMP_W-1:0]          cmp_valid,
  input  logic [CMP_W-1:0][PW-1:0]  cmp_idx,

  input  logic [RET_W-1:0]          ret_valid,
  input  logic [RET_W-1:0][PW-1:0]  ret_idx,

  input  logic                      ckpt_save,
  input  logic [CW-1:0]             ckpt_save_id,
  input  logic                      ckpt_restore,
  input  logic [CW-1:0]             ckpt_restore_id,
  input  logic                      ckpt_release,
  input  logic [CW-1:0]             ckpt_release_id,

  output logic [NUM_PREGS-1:0]      ready_list,
  output logic [NUM_PREGS-1:0]      next_ready_list,
  output logic [NUM_PREGS-1:0]      free_list
);

  // Architectural registers start mapped onto pregs 0..NUM_AREGS-1,
  // so those are busy but ready; the rest are free.
  localparam logic [NUM_PREGS-1:0] FREE_RST =
    {{(NUM_PREGS - NUM_AREGS){1'b1}}, {NUM_AREGS{1'b0}}};
  localparam logic [NUM_PREGS-1:0] READY_RST =
    {{(NUM_PREGS - NUM_AREGS){1'b0}}, {NUM_AREGS{1'b1}}};
  localparam logic [FW-1:0] FREE_CNT_RST = FW'(NUM_PREGS - NUM_AREGS);

  // ------------------------------------------------------------------------
  // State
  // ------------------------------------------------------------------------
  logic [NUM_PREGS-1:0]                free_q,       free_d;
  logic [NUM_PREGS-1:0]                ready_q,      ready_d;
  logic [FW-1:0]                       free_count_q, free_count_d;
  logic [NUM_CKPT-1:0][NUM_PREGS-1:0]  ckpt_q,       ckpt_d;
  logic [NUM_CKPT-1:0]                 ckpt_vld_q,   ckpt_vld_d;

  // ------------------------------------------------------------------------
  // Combinational helpers
  // ------------------------------------------------------------------------
  logic [ALLOC_W-1:0][PW-1:0] alloc_idx;
  logic                       alloc_gnt;
  logic [NUM_PREGS-1:0]       alloc_mask;
  logic [NUM_PREGS-1:0]       ret_mask;
  logic [NUM_PREGS-1:0]       cmp_mask;

  function automatic logic [FW-1:0] popcount(input logic [NUM_PREGS-1:0] v);
    logic [FW-1:0] c;
    c = '0;
    for (int i = 0; i < NUM_PREGS; i++) begin
      c = c + FW'(v[i]);
    end
    return c;
  endfunction

  // Lowest-first picker. Each slot takes the lowest bit still set in the
  // remaining vector, then removes it. Slots with nothing left drive 0.
  always_comb begin
    logic [NUM_PREGS-1:0] rem;
    rem       = free_q;
    alloc_idx = '0;
    for (int k = 0; k < ALLOC_W; k++) begin
      for (int i = NUM_PREGS - 1; i >= 0; i--) begin
        if (rem[i]) begin
          alloc_idx[k] = PW'(i);
        end
      end
      if (|rem) begin
        rem[alloc_idx[k]] = 1'b0;
      end
    end
  end

  // All-or-nothing grant against the registered count. Registers freed this
  // cycle only show up in free_count next cycle, so there is no free->alloc
  // bypass. A restore or an asserted reset kills the grant.
  assign alloc_gnt = reset
                  && (alloc_bus.alloc_req != '0)
                  && (FW'(alloc_bus.alloc_req) <= free_count_q)
                  && !ckpt_restore;

  always_comb begin
    alloc_mask = '0;
    for (int k = 0; k < ALLOC_W; k++) begin
      if (alloc_gnt && (AW'(k) < alloc_bus.alloc_req)) begin
        alloc_mask[alloc_idx[k]] = 1'b1;
      end
    end
  end

  always_comb begin
    ret_mask = '0;
    for (int r = 0; r < RET_W; r++) begin
      if (ret_valid[r]) begin
        ret_mask[ret_idx[r]] = 1'b1;
      end
    end
  end

  always_comb begin
    cmp_mask = '0;
    for (int c = 0; c < CMP_W; c++) begin
      if (cmp_valid[c]) begin
        cmp_mask[cmp_idx[c]] = 1'b1;
      end
    end
  end

  // ------------------------------------------------------------------------
  // Next-state
  // ------------------------------------------------------------------------
  always_comb begin
    // The allocation clear overrides a same-cycle completion of the same bit.
    ready_d = (ready_q | cmp_mask) & ~alloc_mask;

    // Retirements still land on top of a restored list. The ready list is
    // not restored.
    if (ckpt_restore) begin
      free_d = ckpt_q[ckpt_restore_id] | ret_mask;
    end else begin
      free_d = (free_q & ~alloc_mask) | ret_mask;
    end

    free_count_d = popcount(free_d);

    // Every live checkpoint absorbs retirements. A snapshot taken before a
    // T_old retires must still see it as free after a later restore.
    ckpt_vld_d = ckpt_vld_q;
    for (int j = 0; j < NUM_CKPT; j++) begin
      ckpt_d[j] = ckpt_vld_q[j] ? (ckpt_q[j] | ret_mask) : ckpt_q[j];
    end

    if (ckpt_release) begin
      ckpt_vld_d[ckpt_release_id] = 1'b0;
    end

    // The save is applied after the release, so a save to the same slot
    // wins. Saves are dropped during a restore.
    if (ckpt_save && !ckpt_restore) begin
      ckpt_d[ckpt_save_id]     = free_d;
      ckpt_vld_d[ckpt_save_id] = 1'b1;
    end
  end

  // ------------------------------------------------------------------------
  // Registers
  // ------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      free_q       <= FREE_RST;
      ready_q      <= READY_RST;
      free_count_q <= FREE_CNT_RST;
      ckpt_q       <= '0;
      ckpt_vld_q   <= '0;
    end else begin
      free_q       <= free_d;
      ready_q      <= ready_d;
      free_count_q <= free_count_d;
      ckpt_q       <= ckpt_d;
      ckpt_vld_q   <= ckpt_vld_d;
    end
  end

  // ------------------------------------------------------------------------
  // Outputs
  // ------------------------------------------------------------------------
  assign alloc_bus.alloc_gnt  = alloc_gnt;
  assign alloc_bus.alloc_idx  = alloc_idx;
  assign alloc_bus.free_count = free_count_q;
  assign ready_list           = ready_q;
  assign next_ready_list      = ready_d;
  assign free_list            = free_q;

  // ------------------------------------------------------------------------
  // Illegal-input checks
  // ------------------------------------------------------------------------
  a_alloc_req_range: assert property (@(posedge clock) disable iff (!reset)
    alloc_bus.alloc_req <= AW'(ALLOC_W))
    else $error("alloc_req above ALLOC_W");

  a_restore_valid: assert property (@(posedge clock) disable iff (!reset)
    ckpt_restore |-> ckpt_vld_q[ckpt_restore_id])
    else $error("restore of an invalid checkpoint slot");

  a_alloc_cmp_overlap: assert property (@(posedge clock) disable iff (!reset)
    (alloc_mask & cmp_mask) == '0)
    else $error("completion of a preg being allocated this cycle");

  for (genvar r = 0; r < RET_W; r++) begin : g_ret_chk
    a_ret_range: assert property (@(posedge clock) disable iff (!reset)
      ret_valid[r] |-> (int'(ret_idx[r]) < NUM_PREGS))
      else $error("retire index out of range");

    a_ret_not_free: assert property (@(posedge clock) disable iff (!reset)
      ret_valid[r] |-> !free_q[ret_idx[r]])
      else $error("retire of an already-free preg");
  end

  for (genvar c = 0; c < CMP_W; c++) begin : g_cmp_chk
    a_cmp_range: assert property (@(posedge clock) disable iff (!reset)
      cmp_valid[c] |-> (int'(cmp_idx[c]) < NUM_PREGS))
      else $error("completion index out of range");
  end

endmodule

// File: tb/tb_phys_reg_tracker.sv
module tb_phys_reg_tracker;
  localparam int NUM_PREGS = 64;
  localparam int NUM_AREGS = 32;
  localparam int ALLOC_W   = 3;
  localparam int CMP_W     = 3;
  localparam int RET_W     = 3;
  localparam int NUM_CKPT  = 8;
  localparam int PW        = 6;
  localparam int CW        = 3;

  logic clock = 1'b0;
  logic reset = 1'b0;

  logic [CMP_W-1:0]          cmp_valid;
  logic [CMP_W-1:0][PW-1:0]  cmp_idx;
  logic [RET_W-1:0]          ret_valid;
  logic [RET_W-1:0][PW-1:0]  ret_idx;
  logic                      ckpt_save;
  logic [CW-1:0]             ckpt_save_id;
  logic                      ckpt_restore;
  logic [CW-1:0]             ckpt_restore_id;
  logic                      ckpt_release;
  logic [CW-1:0]             ckpt_release_id;
  logic [NUM_PREGS-1:0]      ready_list;
  logic [NUM_PREGS-1:0]      next_ready_list;
  logic [NUM_PREGS-1:0]      free_list;

  phys_reg_tracker_if #(.NUM_PREGS(NUM_PREGS), .ALLOC_W(ALLOC_W)) abus ();

  phys_reg_tracker #(
    .NUM_PREGS (NUM_PREGS),
    .NUM_AREGS (NUM_AREGS),
    .ALLOC_W   (ALLOC_W),
    .CMP_W     (CMP_W),
    .RET_W     (RET_W),
    .NUM_CKPT  (NUM_CKPT)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .alloc_bus       (abus),
    .cmp_valid       (cmp_valid),
    .cmp_idx         (cmp_idx),
    .ret_valid       (ret_valid),
    .ret_idx         (ret_idx),
    .ckpt_save       (ckpt_save),
    .ckpt_save_id    (ckpt_save_id),
    .ckpt_restore    (ckpt_restore),
    .ckpt_restore_id (ckpt_restore_id),
    .ckpt_release    (ckpt_release),
    .ckpt_release_id (ckpt_release_id),
    .ready_list      (ready_list),
    .next_ready_list (next_ready_list),
    .free_list       (free_list)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_idx(input string tag, input int a0, input int a1, input int a2);
    check({tag, "_idx0"}, 64'(abus.alloc_idx[0]), 64'(a0));
    check({tag, "_idx1"}, 64'(abus.alloc_idx[1]), 64'(a1));
    check({tag, "_idx2"}, 64'(abus.alloc_idx[2]), 64'(a2));
  endtask

  task automatic idle();
    abus.alloc_req  = '0;
    cmp_valid       = '0;
    cmp_idx         = '0;
    ret_valid       = '0;
    ret_idx         = '0;
    ckpt_save       = 1'b0;
    ckpt_save_id    = '0;
    ckpt_restore    = 1'b0;
    ckpt_restore_id = '0;
    ckpt_release    = 1'b0;
    ckpt_release_id = '0;
  endtask

  // Advance one clock; leaves time at posedge + 1.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    idle();
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;

    // Reset state
    check("rst_free_count", 64'(abus.free_count), 64'd32);
    check("rst_free_list",  free_list,  64'hFFFF_FFFF_0000_0000);
    check("rst_ready_list", ready_list, 64'h0000_0000_FFFF_FFFF);
    check("rst_gnt",        64'(abus.alloc_gnt), 64'd0);
    check_idx("rst", 32, 33, 34);

    reset = 1'b1;
    tick();

    // Allocate 32..34 and snapshot the result into slot 3
    abus.alloc_req = 3; ckpt_save = 1'b1; ckpt_save_id = 3'd3;
    #1;
    check("a_gnt", 64'(abus.alloc_gnt), 64'd1);
    check_idx("a", 32, 33, 34);
    tick(); idle();
    check("a_free_count", 64'(abus.free_count), 64'd29);
    check("a_ready_list", ready_list, 64'h0000_0000_FFFF_FFFF);
    check("a_free_list",  free_list,  64'hFFFF_FFF8_0000_0000);

    // Allocate 35..37 and retire preg 5
    abus.alloc_req = 3; ret_valid = 3'b001; ret_idx[0] = 6'd5;
    #1;
    check("b_gnt", 64'(abus.alloc_gnt), 64'd1);
    check_idx("b", 35, 36, 37);
    tick(); idle();
    check("b_free_list",  free_list, 64'hFFFF_FFC0_0000_0020);
    check("b_free_count", 64'(abus.free_count), 64'd27);

    // Restore slot 3: 32..34 stay allocated, 35..37 come back, 5 is kept
    ckpt_restore = 1'b1; ckpt_restore_id = 3'd3;
    tick(); idle();
    check("c_free_list",  free_list, 64'hFFFF_FFF8_0000_0020);
    check("c_free_count", 64'(abus.free_count), 64'd30);

    // Restore together with an allocation request and a retire of preg 7
    ckpt_restore = 1'b1; ckpt_restore_id = 3'd3;
    abus.alloc_req = 2; ret_valid = 3'b001; ret_idx[0] = 6'd7;
    #1;
    check("d_gnt", 64'(abus.alloc_gnt), 64'd0);
    tick(); idle();
    check("d_free_list",  free_list, 64'hFFFF_FFF8_0000_00A0);
    check("d_free_count", 64'(abus.free_count), 64'd31);
    check("d_ready_list", ready_list, 64'h0000_0000_FFFF_FFFF);

    ckpt_release = 1'b1; ckpt_release_id = 3'd3;
    tick(); idle();

    // Drain 29 registers (5, 7, 35..61), leaving 62 and 63
    for (int c = 0; c < 10; c++) begin
      abus.alloc_req = (c < 9) ? 2'd3 : 2'd2;
      #1;
      check("drain_gnt", 64'(abus.alloc_gnt), 64'd1);
      tick(); idle();
    end
    check("drain_free_count", 64'(abus.free_count), 64'd2);
    check("drain_free_list",  free_list,  64'hC000_0000_0000_0000);
    check("drain_ready_list", ready_list, 64'h0000_0000_FFFF_FF5F);

    // Request larger than free_count is denied outright
    abus.alloc_req = 3;
    #1;
    check("over_gnt", 64'(abus.alloc_gnt), 64'd0);
    check_idx("over", 62, 63, 0);
    tick(); idle();
    check("over_free_count", 64'(abus.free_count), 64'd2);
    check("over_free_list",  free_list, 64'hC000_0000_0000_0000);

    abus.alloc_req = 2;
    #1;
    check("last2_gnt", 64'(abus.alloc_gnt), 64'd1);
    check_idx("last2", 62, 63, 0);
    tick(); idle();
    check("empty_free_count", 64'(abus.free_count), 64'd0);
    check("empty_free_list",  free_list, 64'h0);

    abus.alloc_req = 1;
    #1;
    check("empty_gnt", 64'(abus.alloc_gnt), 64'd0);
    check_idx("empty", 0, 0, 0);
    tick(); idle();

    // Complete 40 and 41 on CDB ports 0 and 2
    cmp_valid = 3'b101; cmp_idx[0] = 6'd40; cmp_idx[2] = 6'd41;
    #1;
    check("cmp_next_ready", next_ready_list, 64'h0000_0300_FFFF_FF5F);
    check("cmp_ready_old",  ready_list,      64'h0000_0000_FFFF_FF5F);
    tick(); idle();
    check("cmp_ready_new",  ready_list,      64'h0000_0300_FFFF_FF5F);

    // A freed preg is not allocatable in the cycle it is freed
    ret_valid = 3'b001; ret_idx[0] = 6'd10; abus.alloc_req = 1;
    #1;
    check("nobypass_gnt", 64'(abus.alloc_gnt), 64'd0);
    tick(); idle();
    check("nobypass_count", 64'(abus.free_count), 64'd1);
    abus.alloc_req = 1;
    #1;
    check("realloc_gnt", 64'(abus.alloc_gnt), 64'd1);
    check_idx("realloc", 10, 0, 0);
    tick(); idle();
    check("realloc_count", 64'(abus.free_count), 64'd0);

    // Fill three checkpoint slots during a burst
    ret_valid = 3'b111; ret_idx[0] = 6'd20; ret_idx[1] = 6'd21; ret_idx[2] = 6'd22;
    ckpt_save = 1'b1; ckpt_save_id = 3'd0;
    tick(); idle();
    check("burst_count", 64'(abus.free_count), 64'd3);
    abus.alloc_req = 3; ckpt_save = 1'b1; ckpt_save_id = 3'd1;
    #1;
    check("burst_gnt", 64'(abus.alloc_gnt), 64'd1);
    tick(); idle();
    ret_valid = 3'b001; ret_idx[0] = 6'd23; ckpt_save = 1'b1; ckpt_save_id = 3'd2;
    tick(); idle();

    // Reset mid-cycle with a grant pending
    abus.alloc_req = 1;
    #1;
    check("pre_rst_gnt", 64'(abus.alloc_gnt), 64'd1);
    check_idx("pre_rst", 23, 0, 0);
    #1;
    reset = 1'b0;
    #1;
    check("mid_rst_gnt",        64'(abus.alloc_gnt), 64'd0);
    check("mid_rst_free_count", 64'(abus.free_count), 64'd32);
    check("mid_rst_free_list",  free_list,  64'hFFFF_FFFF_0000_0000);
    check("mid_rst_ready_list", ready_list, 64'h0000_0000_FFFF_FFFF);
    check_idx("mid_rst", 32, 33, 34);
    idle();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    tick();
    check("post_rst_free_count", 64'(abus.free_count), 64'd32);
    check("post_rst_free_list",  free_list, 64'hFFFF_FFFF_0000_0000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/phys_reg_tracker.md
# phys_reg_tracker

Parametrised successor to the rename free/ready list: holds the physical-register free list and ready (complete) list for the R10K core. It allocates up to `ALLOC_W` registers per cycle through an all-or-nothing request/grant handshake and frees retired T_old registers. It also keeps `NUM_CKPT` internal branch checkpoints, which are continuously updated with retirements so a mispredict restores an exact free list. Sits between dispatch (allocation), CDB (completion), retire (free) and the branch stack (checkpoint save/restore/release).

## Interface
- `NUM_PREGS`, 64, number of physical registers
- `NUM_AREGS`, 32, number of architectural registers; pregs `0..NUM_AREGS-1` are mapped at reset
- `ALLOC_W`, 3, max allocations per cycle
- `CMP_W`, 3, CDB completion ports
- `RET_W`, 3, retire free ports
- `NUM_CKPT`, 8, checkpoint slots
- Derived widths: `PW = $clog2(NUM_PREGS)`, `CW = $clog2(NUM_CKPT)`, `AW = $clog2(ALLOC_W+1)`, `FW = $clog2(NUM_PREGS+1)`
- `clock` in 1: sole clock, rising edge
- `reset` in 1: asynchronous, active-low
- `alloc_req` in AW: number of registers dispatch wants this cycle (0..ALLOC_W)
- `alloc_gnt` out 1: request granted; comb
- `alloc_idx` out ALLOC_W×PW: lowest-index free pregs, slot 0 = lowest; comb
- `free_count` out FW: registered popcount of the free list
- `cmp_valid` in CMP_W, `cmp_idx` in CMP_W×PW: completing T_new
- `ret_valid` in RET_W, `ret_idx` in RET_W×PW: retiring T_old to free
- `ckpt_save` in 1, `ckpt_save_id` in CW: snapshot into slot
- `ckpt_restore` in 1, `ckpt_restore_id` in CW: mispredict restore
- `ckpt_release` in 1, `ckpt_release_id` in CW: branch resolved correctly; slot invalidated
- `ready_list` out NUM_PREGS: registered ready bits
- `next_ready_list` out NUM_PREGS: comb next-state ready bits, for issue wakeup bypass
- `free_list` out NUM_PREGS: registered free bits

## Operation
- Grant: `alloc_gnt = (alloc_req != 0) && (alloc_req <= free_count) && !ckpt_restore`. There are no partial grants.
- `alloc_idx[k]` is valid for `k < min(free_count, ALLOC_W)` whether or not a grant occurs. Unused slots drive 0.
- On grant, the first `alloc_req` entries of `alloc_idx` are cleared in the free list and cleared in the ready list.
- Retire: for each valid `ret_idx`, set the free bit. Also set that bit in every valid checkpoint slot.
- Complete: for each valid `cmp_idx`, set the ready bit. If allocation-clear and completion hit the same bit in one cycle, the allocation clear wins. This case is illegal upstream; flag it with an assertion.
- Next free list: `(free & ~alloc_mask) | ret_mask`.
- Save: `ckpt[save_id] <= next free list`, i.e. after this cycle's allocations and retirements. Mark the slot valid.
- Restore:
  - `free_list <= ckpt[restore_id] | ret_mask`. The slot must be valid; assert otherwise.
  - The restored slot and all other slots are left unchanged; the branch stack releases younger slots.
  - The ready list is not restored. Completions still apply.
- Release: clear the slot valid bit.
- Priority in one cycle is restore > save/alloc.
  - Save is ignored during restore.
  - Save and release on the same id: save wins.
- `free_count` is the registered popcount of the next free list, at width FW.
- Illegal-input assertions:
  - retire of an already-free preg
  - `alloc_req > ALLOC_W`
  - index `>= NUM_PREGS`

## Timing
- Reset (async assert, released synchronously to `clock`):
  - `free_list` bits `[NUM_AREGS..NUM_PREGS-1]` = 1, others 0
  - `ready_list` bits `[0..NUM_AREGS-1]` = 1, others 0
  - all checkpoint slots invalid and zero
  - `free_count = NUM_PREGS-NUM_AREGS`
  - `alloc_gnt` = 0
- Reset mid-operation discards all state, including pending grants.
- Grant is same-cycle combinational. Freed registers become allocatable the next cycle; there is no same-cycle free→alloc bypass.
- Completion is visible on `next_ready_list` the same cycle and on `ready_list` the next cycle.
- Restore takes effect on the cycle after `ckpt_restore` is asserted. `alloc_gnt` is 0 during the restore cycle.
- Empty: `free_count == 0` means any nonzero request is denied. Full: all pregs free is legal.

## Test plan
- Reset → `free_count`=32, `alloc_idx`={32,33,34}, `ready_list`=0x0000_0000_FFFF_FFFF; with `alloc_req`=3 the next cycle shows `free_count`=29 and ready bits 32–34 = 0.
- Drain to 2 free (pregs 62,63), then `alloc_req`=3 → `alloc_gnt`=0 and state unchanged. Then `alloc_req`=2 → granted {62,63}, `free_count`=0.
- Complete 40 and 41 on CDB ports 0/2 → `next_ready_list` bits 40,41 set the same cycle and `ready_list` bits set the next cycle.
- Save slot 3 after allocating 32–34, then allocate 35–37 and retire preg 5, then restore slot 3 → `free_list` = reset list minus 32–34 plus 5; `free_count`=30.
- Restore in the same cycle as `alloc_req`=2 and retire of preg 7 → `alloc_gnt`=0; restored list includes 7; no allocation occurs.
- Assert `reset` low mid-burst with 3 slots valid → all outputs return to reset values asynchronously; a restore after reset fires the invalid-slot assertion.
